// File: rtl/ising_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ising_pkg                                                            |
// | Shared FSM state type and width/bound helpers for the Ising block.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ising_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int energy_width(input int vector_size, input int j_width);
        return 2 * $clog2(vector_size) + j_width + 2;
    endfunction

    // Largest possible |contribution| of one column: every row at max |J|.
    function automatic int col_bound(input int vector_size, input int j_width, input bit j_signed);
        return j_signed ? vector_size * (1 << (j_width - 1))
                        : vector_size * ((1 << j_width) - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ising_col_dot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ising_col_dot                                                        |
// | Signed dot product of the spin vector with one J column of a beat.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ising_col_dot import ising_pkg::*; #(
    parameter int VECTOR_SIZE     = 256,
    parameter int J_ELEMENT_WIDTH = 4,
    parameter int J_COLS_PER_CLK  = 4,
    parameter int COL_INDEX       = 0,
    parameter int J_SIGNED        = 0,
    parameter int ENERGY_WIDTH    = energy_width(VECTOR_SIZE, J_ELEMENT_WIDTH)
) (
    input  logic [VECTOR_SIZE-1:0]                                 sigma,
    input  logic [VECTOR_SIZE*J_COLS_PER_CLK*J_ELEMENT_WIDTH-1:0]  j_chunk,
    output logic signed [ENERGY_WIDTH-1:0]                         dot
);

    logic [J_ELEMENT_WIDTH-1:0]     w_elem;
    logic signed [ENERGY_WIDTH-1:0] w_ext;

    always_comb begin
        dot    = '0;
        w_elem = '0;
        w_ext  = '0;
        for (int r = 0; r < VECTOR_SIZE; r++) begin
            w_elem = j_chunk[(r * J_COLS_PER_CLK + COL_INDEX) * J_ELEMENT_WIDTH +: J_ELEMENT_WIDTH];
            if (J_SIGNED != 0) begin
                w_ext = ENERGY_WIDTH'(signed'(w_elem));
            end else begin
                w_ext = ENERGY_WIDTH'(w_elem);
            end
            if (sigma[r]) begin
                dot = dot + w_ext;
            end else begin
                dot = dot - w_ext;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ising_energy_accum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ising_energy_accum                                                   |
// | Streams J column chunks and accumulates sigma^T J sigma with abort   |
// | and bound-based early termination.                                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ising_energy_accum import ising_pkg::*; #(
    parameter int VECTOR_SIZE     = 256,
    parameter int J_ELEMENT_WIDTH = 4,
    parameter int J_COLS_PER_CLK  = 4,
    parameter int J_SIGNED        = 0,
    localparam int NUM_J_CHUNKS   = VECTOR_SIZE / J_COLS_PER_CLK,
    localparam int ENERGY_WIDTH   = energy_width(VECTOR_SIZE, J_ELEMENT_WIDTH)
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   start,
    input  logic                                                   abort,
    input  logic                                                   early_stop_en,
    input  logic [VECTOR_SIZE-1:0]                                 sigma,
    input  logic signed [ENERGY_WIDTH-1:0]                         energy_prev,
    input  logic                                                   j_valid,
    output logic                                                   j_ready,
    input  logic [VECTOR_SIZE*J_COLS_PER_CLK*J_ELEMENT_WIDTH-1:0]  j_chunk,
    output logic                                                   busy,
    output logic                                                   done,
    output logic signed [ENERGY_WIDTH-1:0]                         energy_out,
    output logic                                                   energy_exceeded,
    output logic                                                   early_stop,
    output logic                                                   aborted
);

    localparam int c_chunk_w = (NUM_J_CHUNKS > 1) ? $clog2(NUM_J_CHUNKS) : 1;
    localparam logic [c_chunk_w-1:0] c_last_chunk = c_chunk_w'(NUM_J_CHUNKS - 1);
    localparam logic signed [ENERGY_WIDTH-1:0] c_beat_bound =
        ENERGY_WIDTH'(J_COLS_PER_CLK * col_bound(VECTOR_SIZE, J_ELEMENT_WIDTH, J_SIGNED != 0));

    state_t                         r_state, w_state_next;
    logic [VECTOR_SIZE-1:0]         r_sigma;
    logic signed [ENERGY_WIDTH-1:0] r_energy_prev, r_acc, r_energy_out;
    logic [c_chunk_w-1:0]           r_chunk;
    logic                           r_exceeded, r_early_stop, r_aborted;

    logic signed [ENERGY_WIDTH-1:0] w_dot [J_COLS_PER_CLK];
    logic [J_COLS_PER_CLK-1:0]      w_sig_grp [NUM_J_CHUNKS];
    logic signed [ENERGY_WIDTH-1:0] w_block, w_acc_new, w_rem_chunks, w_rem_bound;
    logic                           w_accept, w_last, w_stop, w_finish;

    for (genvar c = 0; c < J_COLS_PER_CLK; c++) begin : g_col
        ising_col_dot #(
            .VECTOR_SIZE     (VECTOR_SIZE),
            .J_ELEMENT_WIDTH (J_ELEMENT_WIDTH),
            .J_COLS_PER_CLK  (J_COLS_PER_CLK),
            .COL_INDEX       (c),
            .J_SIGNED        (J_SIGNED),
            .ENERGY_WIDTH    (ENERGY_WIDTH)
        ) u_col_dot (
            .sigma   (r_sigma),
            .j_chunk (j_chunk),
            .dot     (w_dot[c])
        );
    end

    // Spins of the columns carried by each beat, selected by the chunk counter.
    for (genvar k = 0; k < NUM_J_CHUNKS; k++) begin : g_grp
        assign w_sig_grp[k] = r_sigma[k*J_COLS_PER_CLK +: J_COLS_PER_CLK];
    end

    always_comb begin
        w_block = '0;
        for (int c = 0; c < J_COLS_PER_CLK; c++) begin
            if (w_sig_grp[r_chunk][c]) begin
                w_block = w_block + w_dot[c];
            end else begin
                w_block = w_block - w_dot[c];
            end
        end
    end

    // Abort takes priority, so an aborting cycle never counts as a beat.
    assign w_accept     = (r_state == ST_RUN) && j_valid && !abort;
    assign w_last       = (r_chunk == c_last_chunk);
    assign w_acc_new    = r_acc + w_block;
    assign w_rem_chunks = ENERGY_WIDTH'(c_last_chunk - r_chunk);
    assign w_rem_bound  = w_rem_chunks * c_beat_bound;
    assign w_stop       = early_stop_en && !w_last && ((w_acc_new - w_rem_bound) >= r_energy_prev);
    assign w_finish     = w_accept && (w_last || w_stop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_RUN;
            ST_RUN: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_finish) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sigma       <= '0;
            r_energy_prev <= '0;
            r_acc         <= '0;
            r_chunk       <= '0;
            r_energy_out  <= '0;
            r_exceeded    <= 1'b0;
            r_early_stop  <= 1'b0;
            r_aborted     <= 1'b0;
        end else begin
            r_aborted <= (r_state == ST_RUN) && abort;
            if ((r_state == ST_IDLE) && start) begin
                r_sigma       <= sigma;
                r_energy_prev <= energy_prev;
                r_acc         <= '0;
                r_chunk       <= '0;
            end
            if (w_accept) begin
                r_acc   <= w_acc_new;
                r_chunk <= r_chunk + 1'b1;
            end
            if (w_finish) begin
                r_energy_out <= w_acc_new;
                r_exceeded   <= (w_acc_new >= r_energy_prev);
                r_early_stop <= w_stop;
            end
        end
    end

    assign j_ready         = (r_state == ST_RUN);
    assign busy            = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign done            = (r_state == ST_DONE);
    assign energy_out      = r_energy_out;
    assign energy_exceeded = r_exceeded;
    assign early_stop      = r_early_stop;
    assign aborted         = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_ising_energy_accum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ising_energy_accum                                                |
// | Unsigned and signed instances checked against an energy model.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ising_energy_accum;

    localparam int V   = 8;
    localparam int W   = 4;
    localparam int C   = 2;
    localparam int NCH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               start = 1'b0, abort = 1'b0, early_stop_en = 1'b0, j_valid = 1'b0;
    logic [V-1:0]       sigma = '0;
    logic signed [11:0] energy_prev = '0;
    logic [63:0]        j_chunk = '0;

    logic               j_ready_w [2];
    logic               busy_w [2];
    logic               done_w [2];
    logic               exc_w [2];
    logic               es_w [2];
    logic               ab_w [2];
    logic signed [11:0] eo_w [2];

    ising_energy_accum #(.VECTOR_SIZE(V), .J_ELEMENT_WIDTH(W), .J_COLS_PER_CLK(C), .J_SIGNED(0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .early_stop_en(early_stop_en),
        .sigma(sigma), .energy_prev(energy_prev), .j_valid(j_valid), .j_ready(j_ready_w[0]),
        .j_chunk(j_chunk), .busy(busy_w[0]), .done(done_w[0]), .energy_out(eo_w[0]),
        .energy_exceeded(exc_w[0]), .early_stop(es_w[0]), .aborted(ab_w[0]));

    ising_energy_accum #(.VECTOR_SIZE(V), .J_ELEMENT_WIDTH(W), .J_COLS_PER_CLK(C), .J_SIGNED(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .early_stop_en(early_stop_en),
        .sigma(sigma), .energy_prev(energy_prev), .j_valid(j_valid), .j_ready(j_ready_w[1]),
        .j_chunk(j_chunk), .busy(busy_w[1]), .done(done_w[1]), .energy_out(eo_w[1]),
        .energy_exceeded(exc_w[1]), .early_stop(es_w[1]), .aborted(ab_w[1]));

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Energy contribution of beat k: sum over its columns c of s_c * sum_r s_r*J[r][c].
    function automatic int block_energy(input logic [7:0] s, input logic [63:0] jc, input int k, input bit sg);
        int tot = 0;
        for (int c = 0; c < C; c++) begin
            int dot = 0;
            int col = k * C + c;
            for (int r = 0; r < V; r++) begin
                int jv = int'(jc[(r * C + c) * W +: W]);
                if (sg && jv >= 8) jv -= 16;
                dot += (s[r] ? 1 : -1) * jv;
            end
            tot += (s[col] ? 1 : -1) * dot;
        end
        return tot;
    endfunction

    // Model: mode 0 idle, 1 streaming, 2 done; per instance (index 1 = signed J).
    int         m_mode [2];
    int         m_beat [2];
    int         m_acc [2];
    int         m_out [2];
    int         m_prev [2];
    logic [7:0] m_sig [2];
    bit         m_exc [2];
    bit         m_es [2];
    bit         m_ab [2];

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            automatic int nacc;
            automatic bit last;
            automatic bit stp;
            automatic int max_j;
            if (!rst_n) begin
                m_mode[d] <= 0; m_beat[d] <= 0; m_acc[d] <= 0; m_out[d] <= 0;
                m_prev[d] <= 0; m_sig[d] <= '0; m_exc[d] <= 0; m_es[d] <= 0; m_ab[d] <= 0;
            end else begin
                m_ab[d] <= 1'b0;
                if (m_mode[d] == 0) begin
                    if (start) begin
                        m_mode[d] <= 1; m_beat[d] <= 0; m_acc[d] <= 0;
                        m_sig[d] <= sigma; m_prev[d] <= int'(energy_prev);
                    end
                end else if (m_mode[d] == 1) begin
                    if (abort) begin
                        m_mode[d] <= 0;
                        m_ab[d]   <= 1'b1;
                    end else if (j_valid) begin
                        max_j = (d == 1) ? 8 : 15;
                        nacc  = m_acc[d] + block_energy(m_sig[d], j_chunk, m_beat[d], d == 1);
                        last  = (m_beat[d] == NCH - 1);
                        stp   = early_stop_en && !last &&
                                (nacc - (V - (m_beat[d] + 1) * C) * V * max_j >= m_prev[d]);
                        m_acc[d]  <= nacc;
                        m_beat[d] <= m_beat[d] + 1;
                        if (last || stp) begin
                            m_mode[d] <= 2;
                            m_out[d]  <= nacc;
                            m_exc[d]  <= (nacc >= m_prev[d]);
                            m_es[d]   <= stp;
                        end
                    end
                end else begin
                    m_mode[d] <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("dut%0d busy", d),     int'(busy_w[d]),    int'(m_mode[d] != 0));
                check($sformatf("dut%0d done", d),     int'(done_w[d]),    int'(m_mode[d] == 2));
                check($sformatf("dut%0d j_ready", d),  int'(j_ready_w[d]), int'(m_mode[d] == 1));
                check($sformatf("dut%0d energy", d),   int'(eo_w[d]),      m_out[d]);
                check($sformatf("dut%0d exceeded", d), int'(exc_w[d]),     int'(m_exc[d]));
                check($sformatf("dut%0d early", d),    int'(es_w[d]),      int'(m_es[d]));
                check($sformatf("dut%0d aborted", d),  int'(ab_w[d]),      int'(m_ab[d]));
            end
        end
    end

    task automatic kick(input logic [7:0] s, input int prev, input bit es);
        @(negedge clk);
        sigma = s; energy_prev = prev[11:0]; early_stop_en = es;
        start = 1'b1; abort = 1'b0; j_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        sigma = 8'($urandom);
        energy_prev = 12'($urandom);
    endtask

    task automatic beats(input int n, input bit gap, input logic [63:0] jc);
        for (int i = 0; i < n; i++) begin
            j_valid = gap ? (i % 2 == 0) : 1'b1;
            j_chunk = jc;
            @(negedge clk);
        end
        j_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0; j_valid = 1'b0;
        end
    endtask

    task automatic rand_run();
        automatic int jmode = $urandom_range(0, 2);
        @(negedge clk);
        sigma = 8'($urandom);
        energy_prev = 12'($urandom_range(0, 1200) - 600);
        early_stop_en = 1'($urandom_range(0, 1));
        start = 1'b1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            start   = ($urandom_range(0, 7) == 0);
            abort   = ($urandom_range(0, 29) == 0);
            j_valid = ($urandom_range(0, 2) != 0);
            sigma   = 8'($urandom);
            energy_prev = 12'($urandom);
            case (jmode)
                0: j_chunk = {$urandom, $urandom};
                1: j_chunk = {16{4'hF}};
                default: j_chunk = {$urandom, $urandom} | 64'h7777_7777_7777_7777;
            endcase
        end
        idle(2);
    endtask

    logic [63:0] j_ones, j_fifteen, j_eight;

    initial begin
        j_ones    = {16{4'h1}};
        j_fifteen = {16{4'hF}};
        j_eight   = {16{4'h8}};

        check("model ones blk0",    block_energy(8'hFF, j_ones, 0, 1'b0), 16);
        check("model s03 blk0",     block_energy(8'h03, j_ones, 0, 1'b0), -8);
        check("model F signed",     block_energy(8'hFF, j_fifteen, 0, 1'b1), -16);
        check("model 8 signed",     block_energy(8'hFF, j_eight, 1, 1'b1), -128);

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset busy",    int'(busy_w[0]), 0);
        check("reset j_ready", int'(j_ready_w[1]), 0);
        check("reset energy",  int'(eo_w[0]), 0);
        rst_n = 1'b1;

        kick(8'hFF, 100, 1'b0);
        beats(4, 1'b0, j_ones);
        check("all1 done",     int'(done_w[0]), 1);
        check("all1 energy",   int'(eo_w[0]), 64);
        check("all1 exceeded", int'(exc_w[0]), 0);
        check("all1 signed",   int'(eo_w[1]), 64);
        @(negedge clk);
        check("all1 done one cycle", int'(done_w[0]), 0);

        kick(8'h0F, 0, 1'b0);
        beats(4, 1'b0, j_ones);
        check("s0F energy", int'(eo_w[0]), 0);
        kick(8'h0F, 0, 1'b0);
        beats(7, 1'b1, j_ones);
        check("gap done",   int'(done_w[0]), 1);
        check("gap energy", int'(eo_w[0]), 0);

        kick(8'hFF, 0, 1'b1);
        beats(2, 1'b0, j_fifteen);
        check("early done",     int'(done_w[0]), 1);
        check("early energy",   int'(eo_w[0]), 480);
        check("early flag",     int'(es_w[0]), 1);
        check("early exceeded", int'(exc_w[0]), 1);
        check("signed still busy", int'(busy_w[1]), 1);
        beats(2, 1'b0, j_fifteen);
        check("signed -1 energy", int'(eo_w[1]), -64);
        check("signed -1 flag",   int'(es_w[1]), 0);

        kick(8'hFF, 0, 1'b0);
        beats(4, 1'b0, j_eight);
        check("signed 8 energy",   int'(eo_w[1]), -512);
        check("signed 8 exceeded", int'(exc_w[1]), 0);
        check("unsigned 8 energy", int'(eo_w[0]), 512);

        kick(8'hFF, 0, 1'b0);
        beats(2, 1'b0, j_ones);
        j_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        j_valid = 1'b0; abort = 1'b0;
        check("abort pulse",  int'(ab_w[0]), 1);
        check("abort idle",   int'(busy_w[0]), 0);
        check("abort energy", int'(eo_w[1]), -512);
        @(negedge clk);
        check("abort no done", int'(done_w[0]), 0);
        check("abort one cycle", int'(ab_w[0]), 0);

        kick(8'hFF, 100, 1'b0);
        beats(1, 1'b0, j_ones);
        j_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("midrst busy",    int'(busy_w[0]), 0);
        check("midrst j_ready", int'(j_ready_w[1]), 0);
        check("midrst energy",  int'(eo_w[0]), 0);
        check("midrst energy s", int'(eo_w[1]), 0);
        @(negedge clk);
        rst_n = 1'b1; j_valid = 1'b0;
        kick(8'hFF, 100, 1'b0);
        beats(4, 1'b0, j_ones);
        check("post rst done",   int'(done_w[0]), 1);
        check("post rst energy", int'(eo_w[0]), 64);

        repeat (40) rand_run();
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
